// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared sizing constants and types for the TDM demultiplexer
package tdm_demux_pkg;
    localparam int N_OUT_DEF = 32;
    localparam int SEL_W_DEF = 5;
    typedef logic [N_OUT_DEF-1:0] lane_mask_t;
endpackage

// File: rtl/tdm_lane_tracker.sv
// tdm_lane_tracker: per-frame written-lane mask with frame completion and overrun detection
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clear        synchronous clear of mask and flags
//   hit          one-hot lane written this cycle (all zero when nothing is written)
//   frame_done   1-cycle pulse after the write that completes the mask
//   overrun      sticky flag: a lane was written twice within one frame
module tdm_lane_tracker
    import tdm_demux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [N_OUT-1:0] hit,
    output logic             frame_done,
    output logic             overrun
);
    logic [N_OUT-1:0] mask;
    logic [N_OUT-1:0] mask_nxt;
    logic             full;

    always_comb begin
        mask_nxt = mask | hit;
        full     = (|hit) && (&mask_nxt);
    end

    // The completing write restarts the mask on the same edge that raises frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask       <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mask       <= (clear || full) ? '0 : mask_nxt;
            frame_done <= full;
            overrun    <= !clear && (overrun || |(mask & hit));
        end
    end
endmodule

// File: rtl/tdm_demux32.sv
// tdm_demux32: registered 1-to-N time-division demultiplexer rebuilding a parallel word from serial beats
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     beat can be accepted (reset released and no clear)
//   in_bit       data bit of the beat
//   sel          destination lane (unused when DEMUX_AUTO_SEQ_EN is defined)
//   clear        synchronous clear of lanes, mask, flags and sequence counter
//   out          registered lane values
//   out_strobe   one-hot 1-cycle pulse marking the lane just written
//   frame_done   1-cycle pulse when every lane has been written
//   overrun      sticky: a lane was rewritten before frame_done
// Build option: DEMUX_AUTO_SEQ_EN replaces sel with an internal wrapping lane counter.
module tdm_demux32
    import tdm_demux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear,
    output logic [N_OUT-1:0] out,
    output logic [N_OUT-1:0] out_strobe,
    output logic             frame_done,
    output logic             overrun
);
    logic             ready_q;
    logic             acc;
    logic [SEL_W-1:0] lane;
    logic [N_OUT-1:0] dec;

`ifdef DEMUX_AUTO_SEQ_EN
    logic [SEL_W-1:0] cnt;
    logic             unused_sel;

    assign unused_sel = ^sel;
    assign lane       = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= clear ? '0 : !acc ? cnt : (cnt == SEL_W'(N_OUT - 1)) ? '0 : cnt + 1'b1;
        end
    end
`else
    assign lane = sel;
`endif

    assign in_ready = ready_q && !clear;
    assign acc      = in_valid && in_ready;

    // A lane index beyond N_OUT shifts the one-hot out of range, so such beats decode to nothing.
    assign dec = acc ? ({{(N_OUT-1){1'b0}}, 1'b1} << lane) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            out        <= '0;
            out_strobe <= '0;
        end else begin
            ready_q    <= 1'b1;
            out        <= clear ? '0 : (out & ~dec) | (dec & {N_OUT{in_bit}});
            out_strobe <= dec;
        end
    end

    tdm_lane_tracker #(.N_OUT(N_OUT)) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .hit        (dec),
        .frame_done (frame_done),
        .overrun    (overrun)
    );
endmodule

// File: tb/tb_tdm_demux32.sv
// tb_tdm_demux32: scoreboard bench for tdm_demux32 (sel-driven build, or auto-sequence build with DEMUX_AUTO_SEQ_EN)
module tb_tdm_demux32;
    import tdm_demux_pkg::*;

    typedef struct packed {
        logic [31:0] strobe;
        logic [31:0] out;
        logic        fd;
        logic        ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic [4:0]  sel;
    logic        clear;
    logic [31:0] out;
    logic [31:0] out_strobe;
    logic        frame_done;
    logic        overrun;

    exp_t       sb[$];
    exp_t       mon_e;
    lane_mask_t m_out;
    lane_mask_t m_mask;
    logic       m_ovr;
    int         m_cnt;
    int         errors = 0;
    int         checks = 0;
    int         fd_count = 0;
    int         fd0;

    always #5 clk = ~clk;

    tdm_demux32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .sel        (sel),
        .clear      (clear),
        .out        (out),
        .out_strobe (out_strobe),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (out_strobe != 32'h0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got strobe=%h want=no strobe", out_strobe);
            end else begin
                mon_e = sb.pop_front();
                if ({out_strobe, out, frame_done, overrun} !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard got strobe=%h out=%h fd=%b ovr=%b want strobe=%h out=%h fd=%b ovr=%b",
                             out_strobe, out, frame_done, overrun, mon_e.strobe, mon_e.out, mon_e.fd, mon_e.ovr);
                end
            end
            if (frame_done) fd_count++;
        end else if (frame_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL fd_without_strobe got fd=%b want=0", frame_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_mask = '0;
        m_ovr  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input int s, input logic b);
        exp_t e;
        int   l;
`ifdef DEMUX_AUTO_SEQ_EN
        l     = m_cnt;
        m_cnt = (m_cnt == 31) ? 0 : m_cnt + 1;
`else
        l = s;
`endif
        in_valid  = 1'b1;
        sel       = 5'(s);
        in_bit    = b;
        m_out[l]  = b;
        m_ovr     = m_ovr | m_mask[l];
        m_mask[l] = 1'b1;
        e.fd      = &m_mask;
        if (e.fd) m_mask = '0;
        e.strobe  = 32'h1 << l;
        e.out     = m_out;
        e.ovr     = m_ovr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        sel      = '0;
        model_reset();
        #12;
        check("reset_out", out, 32'h0);
        check("reset_strobe", out_strobe, 32'h0);
        check("reset_flags", {30'h0, frame_done, overrun}, 32'h0);
        check("reset_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("ready_after_edge", {31'h0, in_ready}, 32'h1);
`ifdef DEMUX_AUTO_SEQ_EN
        for (int k = 0; k < 64; k++) beat(0, ~k[0]);
        idle(2);
        check("auto_out", out, 32'h55555555);
        check("auto_fd_count", fd_count, 2);
        check("auto_overrun", {31'h0, overrun}, 32'h0);
`else
        for (int s = 0; s < 32; s++) beat(s, s[0]);
        idle(2);
        check("frame_out", out, 32'hAAAAAAAA);
        check("frame_overrun", {31'h0, overrun}, 32'h0);
        check("frame_fd_count", fd_count, 1);

        beat(5, 1'b1);
        beat(7, 1'b0);
        beat(5, 1'b0);
        idle(3);
        check("overrun_sticky", {31'h0, overrun}, 32'h1);
        do_clear();
        @(negedge clk);
        check("clear_overrun", {31'h0, overrun}, 32'h0);
        check("clear_out", out, 32'h0);

        @(posedge clk);
        #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        sel      = 5'd3;
        in_bit   = 1'b1;
        #1;
        check("clear_blocks_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("clear_wins_out3", {31'h0, out[3]}, 32'h0);
        check("clear_wins_strobe", out_strobe, 32'h0);

        fd0 = fd_count;
        for (int s = 0; s < 10; s++) beat(s, 1'b1);
        idle(1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_out", out, 32'h0);
        check("midreset_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 32; s++) beat(s, 1'b1);
        idle(2);
        check("midreset_fd_count", fd_count - fd0, 1);
        check("midreset_frame_out", out, 32'hFFFFFFFF);
        check("midreset_overrun", {31'h0, overrun}, 32'h0);
`endif
        idle(2);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
